alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_rr_pick.sv | 18 +
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, FSM state type and width defaults
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_STLU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_rr_pick.sv
// rtl/alu_rr_pick.sv - combinational 2-way round-robin picker, one-hot grant
module alu_rr_pick (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // On contention the requester not served last wins; otherwise pass the lone valid through.
    always_comb begin
        grant_o = 2'b00;
        if (valid_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              id_q, id_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_id_q, rsp_id_d;
    logic [1:0]        grant;

    alu_rr_pick u_pick (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = op_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_id_d     = rsp_id_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Gated by rst_n so a request presented during reset is never acknowledged.
                if (rst_n && (grant != 2'b00)) begin
                    req0_ready   = grant[0];
                    req1_ready   = grant[1];
                    a_d          = grant[1] ? req1_a  : req0_a;
                    b_d          = grant[1] ? req1_b  : req0_b;
                    op_d         = grant[1] ? req1_op : req0_op;
                    id_d         = grant[1];
                    last_grant_d = grant[1];
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_id_d     = id_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized scoreboard bench for alu_arbiter
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [31:0] rsp_result;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
        int          acc;
    } exp_t;

    exp_t q[$];
    bit   busy   = 1'b0;
    bit   m_last = 1'b1;
    bit   done_rand;

    alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
            OP_STLU: return {31'b0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    // Shared combinational ALU living outside the DUT
    assign alu_result = alu_ref(alu_ctrl, alu_a, alu_b);
    assign alu_zero   = (alu_result == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor and reference model: grant prediction, response prediction, latency
    always @(negedge clk) begin
        bit          g_valid;
        bit          g;
        bit          exp_v;
        exp_t        e;
        g_valid = 1'b0;
        g       = 1'b0;
        if (rst_n && !busy) begin
            if (req0_valid && req1_valid) begin
                g_valid = 1'b1;
                g       = ~m_last;
            end else if (req0_valid) begin
                g_valid = 1'b1;
                g       = 1'b0;
            end else if (req1_valid) begin
                g_valid = 1'b1;
                g       = 1'b1;
            end
        end
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, g_valid && !g});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, g_valid && g});
        if (!rst_n) begin
            q.delete();
            busy   = 1'b0;
            m_last = 1'b1;
        end else begin
            exp_v = (q.size() > 0) && (cyc >= q[0].acc + 2);
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
            if (rsp_valid && exp_v) begin
                chk("rsp_id", {31'b0, rsp_id}, {31'b0, q[0].id});
                chk("rsp_result", rsp_result, q[0].res);
                chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, q[0].zero});
            end
            if (exp_v && rsp_ready) begin
                void'(q.pop_front());
                busy = 1'b0;
            end
            if (g_valid) begin
                e.id   = g;
                e.res  = g ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
                e.zero = (e.res == 32'd0);
                e.acc  = cyc;
                q.push_back(e);
                busy   = 1'b1;
                m_last = g;
            end
        end
    end

    task automatic send(input bit who, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bit ok;
        if (!who) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (who ? req1_ready : req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: requester %0d never saw ready", who);
        end
        @(posedge clk);
        #1;
        if (!who) req0_valid = 1'b0;
        else      req1_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding", q.size());
        end
        #1;
    endtask

    task automatic rand_req(input bit who, input int n);
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            a = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            send(who, a, b, 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_rsp_zero", {31'b0, rsp_zero}, 32'd0);
        chk("reset_rsp_id", {31'b0, rsp_id}, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_b", alu_b, 32'd0);
        chk("reset_alu_ctrl", {28'b0, alu_ctrl}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single ADD with latency check from the model
        rsp_ready = 1'b1;
        send(1'b0, 32'd5, 32'd7, OP_ADD);
        drain();

        // Continuous contention, grants must alternate
        fork
            begin
                send(1'b0, 32'd9, 32'd9, OP_SUB);
                send(1'b0, 32'd9, 32'd9, OP_SUB);
                send(1'b0, 32'hA5, 32'h5A, OP_OR);
            end
            begin
                send(1'b1, 32'd3, 32'd1, OP_XOR);
                send(1'b1, 32'd3, 32'd1, OP_XOR);
                send(1'b1, 32'hF0, 32'd4, OP_SRL);
            end
        join
        drain();

        // Backpressure: response held 5 cycles with both requesters waiting
        rsp_ready = 1'b0;
        fork
            send(1'b0, 32'd100, 32'd23, OP_SUB);
            send(1'b1, 32'h8000_0000, 32'd3, OP_SRA);
            begin
                ok = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (rsp_valid) begin
                        ok = 1'b1;
                        break;
                    end
                end
                if (!ok) begin
                    checks++;
                    errors++;
                    $display("FAIL stall_wait: rsp_valid never rose");
                end
                repeat (4) @(negedge clk);
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
        join
        drain();

        // Signed vs unsigned compare on requester 1
        send(1'b1, 32'hFFFF_FFFF, 32'd1, OP_SLT);
        send(1'b1, 32'hFFFF_FFFF, 32'd1, OP_STLU);
        drain();

        // Reset during ISSUE discards the operation; req0 wins first contention afterwards
        send(1'b0, 32'd11, 32'd22, OP_ADD);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_alu_a", alu_a, 32'd0);
        chk("post_reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        fork
            send(1'b0, 32'd1, 32'd2, OP_AND);
            send(1'b1, 32'd6, 32'd3, OP_OR);
        join
        drain();

        // Undefined opcode passes through and yields zero
        send(1'b0, 32'h1234, 32'h5678, 4'hF);
        drain();

        // Randomized traffic with random response backpressure
        done_rand = 1'b0;
        fork
            begin
                fork
                    rand_req(1'b0, 40);
                    rand_req(1'b1, 40);
                join
                done_rand = 1'b1;
            end
            begin
                while (!done_rand) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
